mcp_rx_packer: RTL and testbench
================================

// Module: mcp_rx_packer
// PURPOSE
//  Receive-side consumer of mcp_blk in the bclk domain. Drives bload, takes DW-bit words on bvalid,
//  packs NW words into one wide word and presents it downstream with a valid/ready handshake.
//  Partial words are emitted zero-padded on flush or on timeout. Single clock domain; no CDC inside.
// PARAMETERS
//  DW        8    width of one word from mcp_blk
//  NW        4    words per packed output (>=2)
//  TO_CYCLES 64   idle bclk cycles before a partial pack is forced out (MCP_PACK_TIMEOUT_EN only)
// PORTS
//  bclk       in   1           clock (mcp_blk B-side clock)
//  brst_n     in   1           reset: asynchronous assert, active-low
//  bvalid     in   1           mcp_blk bdata holds an unconsumed word
//  bdata      in   DW          word from mcp_blk
//  bload      out  1           consume request to mcp_blk
//  flush      in   1           emit current partial pack (single-cycle pulse)
//  pk_data    out  NW*DW       packed word; word k in bits [k*DW +: DW], first word received = k=0
//  pk_cnt     out  CW          valid words in pk_data, 1..NW; CW = $clog2(NW+1)
//  pk_valid   out  1           pk_data/pk_cnt valid
//  pk_ready   in   1           downstream accepts
//  timeout    out  1           one-cycle pulse: partial pack forced out by the timer
// BEHAVIOUR
//  Reset: state=FILL, idx=0, pk_data=0, pk_cnt=0, pk_valid=0, timeout=0. bload=1 in the first cycle after reset.
//  Transfer rule: a word moves when bvalid & bload in the same bclk cycle; bdata is sampled into lane idx.
//  bload = (state==FILL), combinational from state only; it never depends on bvalid.
//  FSM FILL: each transfer writes lane idx, idx++. Transfer at idx==NW-1 -> HOLD, pk_cnt=NW, pk_valid=1
//    in the next cycle (latency 1 clk from last transfer).
//  FILL + flush, idx>0, no transfer: lanes idx..NW-1 zeroed, pk_cnt=idx -> HOLD.
//  FILL + flush + transfer in the same cycle: the word is stored first. pk_cnt=idx+1, rest zeroed -> HOLD.
//    At idx==NW-1 this is the normal full case.
//  flush with idx==0 and no transfer: ignored. flush in HOLD: ignored (not queued).
//  HOLD: bload=0. pk_data, pk_cnt and pk_valid stay stable until pk_valid & pk_ready.
//    On acceptance -> FILL, idx=0, pk_valid=0 next cycle. Lanes are not cleared; unused lanes of the next
//    partial pack are zeroed when it is emitted.
//  Throughput: no refill during HOLD. Minimum of NW+1 cycles per pack when both sides stream.
//  pk_ready is ignored while pk_valid=0. bvalid while bload=0 is held off by mcp_blk (its own contract).
//  brst_n asserted mid-operation: partial pack discarded, all outputs go to reset values immediately
//    (asynchronous assert). A word mid-handshake in mcp_blk is not consumed.
// CONFIGURATION
//  MCP_PACK_TIMEOUT_EN defined: 16-bit idle counter. It counts bclk cycles in FILL with idx>0 and no transfer,
//    and clears on any transfer, on leaving FILL, and on reset.
//    Reaching TO_CYCLES acts as flush; timeout pulses 1 cycle together with the FILL->HOLD transition.
//    An explicit flush in the same cycle reports timeout=1 as well.
//  Undefined: no counter, timeout tied 0, partial packs leave only via flush.
// STRUCTURE
//  mcp_pkg: typedef enum logic [0:0] {FILL, HOLD} mcp_pack_st_t; helper function cnt_w(NW) = $clog2(NW+1).
//  Sub-module mcp_pack_timer (counter + terminal-count pulse), instantiated only under MCP_PACK_TIMEOUT_EN.
//  Top holds the FSM, lane index, data register and output regs.
// TESTING
//  1 Reset release, bvalid held 1, bdata=11,22,33,44 -> pk_data=0x44332211, pk_cnt=4, pk_valid 1 cycle
//    after the 4th transfer; bload=0 until pk_ready.
//  2 Hold pk_ready=0 for 20 clks in HOLD -> pk_data stable, bload=0, no transfers;
//    pk_ready=1 -> pk_valid drops, bload=1 next cycle.
//  3 Two words A5,5A then flush -> pk_data=0x00005AA5, pk_cnt=2. flush with idx==0 -> no pk_valid.
//  4 flush in the same cycle as 3rd word C3 after 01,02 -> pk_data=0x00C30201, pk_cnt=3.
//  5 (MCP_PACK_TIMEOUT_EN, TO_CYCLES=64) one word 7E, then idle -> timeout pulse and pk_valid after 64 idle clks,
//    pk_cnt=1. Without the macro: no output, timeout stays 0.
//  6 brst_n low after 2 words -> outputs reset asynchronously; after release, a fresh 4-word pack contains no stale lanes.

Source files
------------

// File: rtl/mcp_pkg.sv
// Shared types and helpers for the mcp receive-side packer.
// Optional feature macro: MCP_PACK_TIMEOUT_EN.
package mcp_pkg;

    typedef enum logic [0:0] {
        FILL = 1'b0,
        HOLD = 1'b1
    } mcp_pack_st_t;

    function automatic int cnt_w(input int nw);
        return $clog2(nw + 1);
    endfunction

endpackage

// File: rtl/mcp_pack_timer.sv
// Idle-cycle counter with terminal-count pulse for partial-pack timeout.
// Instantiated only when MCP_PACK_TIMEOUT_EN is defined.
module mcp_pack_timer #(
    parameter int unsigned TO_CYCLES = 64
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic count_i,
    input  logic clr_i,
    output logic tc_o
);

    logic [15:0] cnt_q;
    logic [15:0] cnt_d;

    // Fires on the TO_CYCLES-th consecutive idle cycle, not one later.
    assign tc_o = count_i && (cnt_q == 16'(TO_CYCLES - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (count_i) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mcp_rx_packer.sv
// Packs NW words from mcp_blk into one wide word with valid/ready output.
// Optional partial-pack timeout enabled by MCP_PACK_TIMEOUT_EN.
module mcp_rx_packer
    import mcp_pkg::*;
#(
    parameter int unsigned DW        = 8,
    parameter int unsigned NW        = 4,
    parameter int unsigned TO_CYCLES = 64
) (
    input  logic                   bclk,
    input  logic                   brst_n,
    input  logic                   bvalid,
    input  logic [DW-1:0]          bdata,
    output logic                   bload,
    input  logic                   flush,
    output logic [NW*DW-1:0]       pk_data,
    output logic [cnt_w(NW)-1:0]   pk_cnt,
    output logic                   pk_valid,
    input  logic                   pk_ready,
    output logic                   timeout
);

    localparam int unsigned CW = cnt_w(NW);
    localparam int unsigned IW = $clog2(NW);
    localparam logic [IW-1:0] LAST = IW'(NW - 1);

    if (NW < 2 || TO_CYCLES < 1) begin : g_cfg_err
        $error("mcp_rx_packer: NW must be >= 2 and TO_CYCLES >= 1");
    end

    mcp_pack_st_t            state_q;
    logic [IW-1:0]           idx_q;
    logic [NW-1:0][DW-1:0]   lanes_q;
    logic [NW-1:0][DW-1:0]   lanes_d;
    logic [CW-1:0]           cnt_q;
    logic [CW-1:0]           fill_cnt;
    logic                    valid_q;
    logic                    xfer;
    logic                    tc;
    logic                    flush_eff;
    logic                    go_hold;

    assign bload    = (state_q == FILL);
    assign xfer     = bvalid & bload;
    assign pk_data  = lanes_q;
    assign pk_cnt   = cnt_q;
    assign pk_valid = valid_q;

`ifdef MCP_PACK_TIMEOUT_EN
    logic idle;
    logic timeout_q;

    assign idle    = bload && (idx_q != '0) && !xfer;
    assign timeout = timeout_q;

    mcp_pack_timer #(
        .TO_CYCLES (TO_CYCLES)
    ) u_timer (
        .clk_i   (bclk),
        .rst_ni  (brst_n),
        .count_i (idle),
        .clr_i   (!bload | xfer | go_hold),
        .tc_o    (tc)
    );
`else
    assign tc      = 1'b0;
    assign timeout = 1'b0;
`endif

    assign flush_eff = flush | tc;
    assign fill_cnt  = CW'(idx_q) + CW'(xfer);
    assign go_hold   = bload &&
                       ((xfer && (idx_q == LAST)) ||
                        (flush_eff && (fill_cnt != '0)));

    // Incoming word lands first; lanes beyond the fill level are cleared on emit.
    always_comb begin
        lanes_d = lanes_q;
        if (xfer) begin
            lanes_d[idx_q] = bdata;
        end
        if (go_hold) begin
            for (int k = 0; k < NW; k++) begin
                if (CW'(k) >= fill_cnt) begin
                    lanes_d[k] = '0;
                end
            end
        end
    end

    always_ff @(posedge bclk or negedge brst_n) begin
        if (!brst_n) begin
            state_q   <= FILL;
            idx_q     <= '0;
            lanes_q   <= '0;
            cnt_q     <= '0;
            valid_q   <= 1'b0;
`ifdef MCP_PACK_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
        end else begin
            lanes_q   <= lanes_d;
`ifdef MCP_PACK_TIMEOUT_EN
            timeout_q <= go_hold & tc;
`endif
            unique case (state_q)
                FILL: begin
                    if (go_hold) begin
                        state_q <= HOLD;
                        idx_q   <= '0;
                        cnt_q   <= fill_cnt;
                        valid_q <= 1'b1;
                    end else if (xfer) begin
                        idx_q   <= idx_q + IW'(1);
                    end
                end
                HOLD: begin
                    if (pk_ready) begin
                        state_q <= FILL;
                        valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= FILL;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mcp_rx_packer.sv
// Randomized self-checking bench for mcp_rx_packer with a queue-based model.
// Honors MCP_PACK_TIMEOUT_EN the same way as the design.
module tb_mcp_rx_packer;

    localparam int DW = 8;
    localparam int NW = 4;
    localparam int TO = 64;
    localparam int CW = 3;
`ifdef MCP_PACK_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              bvalid = 1'b0;
    logic [DW-1:0]     bdata = '0;
    logic              flush = 1'b0;
    logic              pk_ready = 1'b0;
    logic              bload;
    logic [NW*DW-1:0]  pk_data;
    logic [CW-1:0]     pk_cnt;
    logic              pk_valid;
    logic              timeout;

    int checks = 0;
    int failures = 0;

    mcp_rx_packer #(.DW(DW), .NW(NW), .TO_CYCLES(TO)) dut (
        .bclk     (clk),
        .brst_n   (rst_n),
        .bvalid   (bvalid),
        .bdata    (bdata),
        .bload    (bload),
        .flush    (flush),
        .pk_data  (pk_data),
        .pk_cnt   (pk_cnt),
        .pk_valid (pk_valid),
        .pk_ready (pk_ready),
        .timeout  (timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Reference model: words of the pack being collected and the held result.
    logic [DW-1:0]    q[$];
    bit               m_hold;
    bit               m_valid;
    bit               m_to;
    logic [NW*DW-1:0] m_data;
    int               m_cnt;
    int               m_idle;

    always @(posedge clk or negedge rst_n) begin
        bit fire;
        if (!rst_n) begin
            q.delete();
            m_hold = 0; m_valid = 0; m_to = 0;
            m_data = '0; m_cnt = 0; m_idle = 0;
        end else if (!m_hold) begin
            m_to = 0;
            if (bvalid) begin
                q.push_back(bdata);
                m_idle = 0;
            end else if (q.size() > 0) begin
                m_idle++;
            end
            fire = TO_EN && !bvalid && q.size() > 0 && m_idle == TO;
            if (q.size() == NW || ((flush || fire) && q.size() > 0)) begin
                m_data = '0;
                foreach (q[k]) m_data[k*DW +: DW] = q[k];
                m_cnt = q.size();
                m_valid = 1; m_to = fire; m_hold = 1;
                q.delete();
                m_idle = 0;
            end
        end else begin
            m_to = 0;
            if (pk_ready) begin
                m_hold = 0;
                m_valid = 0;
            end
        end
    end

    always @(negedge clk) begin
        chk("bload", bload, !m_hold);
        chk("pk_valid", pk_valid, m_valid);
        chk("timeout", timeout, m_to);
        if (m_valid) begin
            chk("pk_data", pk_data, m_data);
            chk("pk_cnt", pk_cnt, m_cnt);
        end
    end

    task automatic step(input logic bv, input logic [DW-1:0] bd,
                        input logic fl, input logic rd);
        @(negedge clk);
        bvalid = bv; bdata = bd; flush = fl; pk_ready = rd;
    endtask

    initial begin
        int k;
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("rst_data", pk_data, 0);
        chk("rst_cnt", pk_cnt, 0);
        chk("rst_valid", pk_valid, 0);
        chk("rst_bload", bload, 1);
        chk("rst_timeout", timeout, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // full pack
        step(1, 8'h11, 0, 0);
        step(1, 8'h22, 0, 0);
        step(1, 8'h33, 0, 0);
        step(1, 8'h44, 0, 0);
        step(0, 0, 0, 0);
        chk("t1_valid", pk_valid, 1);
        chk("t1_data", pk_data, 32'h44332211);
        chk("t1_cnt", pk_cnt, 4);
        chk("t1_bload", bload, 0);

        // backpressure
        repeat (20) step(1, 8'($urandom), 0, 0);
        chk("t2_data", pk_data, 32'h44332211);
        chk("t2_bload", bload, 0);
        step(0, 0, 0, 1);
        step(0, 0, 0, 0);
        chk("t2_valid", pk_valid, 0);
        chk("t2_bload1", bload, 1);

        // flush partial, then flush when empty
        step(1, 8'hA5, 0, 0);
        step(1, 8'h5A, 0, 0);
        step(0, 0, 1, 0);
        step(0, 0, 0, 0);
        chk("t3_data", pk_data, 32'h00005AA5);
        chk("t3_cnt", pk_cnt, 2);
        step(0, 0, 0, 1);
        step(0, 0, 1, 0);
        repeat (4) step(0, 0, 0, 0);
        chk("t3_empty_flush", pk_valid, 0);

        // flush together with a transfer
        step(1, 8'h01, 0, 0);
        step(1, 8'h02, 0, 0);
        step(1, 8'hC3, 1, 0);
        step(0, 0, 0, 0);
        chk("t4_data", pk_data, 32'h00C30201);
        chk("t4_cnt", pk_cnt, 3);
        step(0, 0, 0, 1);

        // idle partial
        step(1, 8'h7E, 0, 0);
`ifdef MCP_PACK_TIMEOUT_EN
        for (k = 1; k <= 100; k++) begin
            step(0, 0, 0, 0);
            if (pk_valid) break;
        end
        chk("t5_latency", k, 65);
        chk("t5_timeout", timeout, 1);
        chk("t5_cnt", pk_cnt, 1);
        chk("t5_data", pk_data, 32'h0000007E);
`else
        repeat (80) step(0, 0, 0, 0);
        chk("t5_no_valid", pk_valid, 0);
        chk("t5_no_timeout", timeout, 0);
        step(0, 0, 1, 0);
        step(0, 0, 0, 0);
        chk("t5_cnt", pk_cnt, 1);
        chk("t5_data", pk_data, 32'h0000007E);
`endif
        step(0, 0, 0, 1);

        // asynchronous reset mid-pack
        step(1, 8'h91, 0, 0);
        step(1, 8'h92, 0, 0);
        step(0, 0, 0, 0);
        chk("t6_pre", pk_data[15:0], 16'h9291);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_data", pk_data, 0);
        chk("t6_rst_valid", pk_valid, 0);
        chk("t6_rst_bload", bload, 1);
        @(negedge clk);
        rst_n = 1'b1;
        step(1, 8'hD1, 0, 0);
        step(1, 8'hD2, 0, 0);
        step(1, 8'hD3, 0, 0);
        step(1, 8'hD4, 0, 0);
        step(0, 0, 0, 0);
        chk("t6_data", pk_data, 32'hD4D3D2D1);
        chk("t6_cnt", pk_cnt, 4);
        step(0, 0, 0, 1);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            if (i % 500 < 90 && i % 500 > 5)
                step(i % 500 == 6, 8'($urandom), 0, $urandom_range(0, 1));
            else
                step($urandom_range(0, 3) != 0, 8'($urandom),
                     $urandom_range(0, 15) == 0, $urandom_range(0, 2) != 0);
        end
        step(0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
